ib_counter_ctrl: RTL and testbench

IB_COUNTER_CTRL -- requirements
Module: ib_counter_ctrl

---
 rtl/ib_counter_ctrl.sv | 108 ++++++++++
 tb/tb_ib_counter_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ib_counter_ctrl.sv
// Prescaled up-counter with one-shot / periodic modes, stop abort and period counting.
// All outputs come straight from registers; the IDLE/RUN FSM is a two-process design.
module ib_counter_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PRE_W = 8
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_limit,
  input  logic [PRE_W-1:0] i_prescale,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_c,
  output logic             o_done,
  output logic [7:0]       o_periods
);

  typedef enum logic {StIdle, StRun} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_c, w_c_nxt;
  logic [WIDTH-1:0]   r_lim, w_lim_nxt;
  logic [PRE_W-1:0]   r_pre, w_pre_nxt;
  logic [PRE_W-1:0]   r_psc, w_psc_nxt;
  logic               r_mode, w_mode_nxt;
  logic               r_done, w_done_nxt;
  logic [7:0]         r_periods, w_periods_nxt;
  logic               w_tick;

  assign w_tick = (r_pre == r_psc);

  always_comb begin
    w_state_nxt   = r_state;
    w_c_nxt       = r_c;
    w_lim_nxt     = r_lim;
    w_pre_nxt     = r_pre;
    w_psc_nxt     = r_psc;
    w_mode_nxt    = r_mode;
    w_done_nxt    = 1'b0;
    w_periods_nxt = r_periods;
    unique case (r_state)
      StIdle: begin
        // Stop is ignored here, so start+stop still launches a run
        if (i_start) begin
          w_lim_nxt     = i_limit;
          w_psc_nxt     = i_prescale;
          w_mode_nxt    = i_mode;
          w_c_nxt       = '0;
          w_pre_nxt     = '0;
          w_periods_nxt = '0;
          w_state_nxt   = StRun;
        end
      end
      StRun: begin
        // Stop wins over a coincident terminal tick: counts freeze, no done pulse
        if (i_stop) begin
          w_state_nxt = StIdle;
        end else if (w_tick) begin
          w_pre_nxt = '0;
          if (r_c != r_lim) begin
            w_c_nxt = r_c + WIDTH'(1);
          end else begin
            w_done_nxt = 1'b1;
            if (r_mode) begin
              w_c_nxt       = '0;
              w_periods_nxt = r_periods + 8'd1;
            end else begin
              w_state_nxt = StIdle;
            end
          end
        end else begin
          w_pre_nxt = r_pre + PRE_W'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state   <= StIdle;
      r_c       <= '0;
      r_lim     <= '0;
      r_pre     <= '0;
      r_psc     <= '0;
      r_mode    <= 1'b0;
      r_done    <= 1'b0;
      r_periods <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_c       <= w_c_nxt;
      r_lim     <= w_lim_nxt;
      r_pre     <= w_pre_nxt;
      r_psc     <= w_psc_nxt;
      r_mode    <= w_mode_nxt;
      r_done    <= w_done_nxt;
      r_periods <= w_periods_nxt;
    end
  end

  assign o_busy    = (r_state == StRun);
  assign o_c       = r_c;
  assign o_done    = r_done;
  assign o_periods = r_periods;

endmodule

// File: tb/tb_ib_counter_ctrl.sv
// Self-checking bench for ib_counter_ctrl: vector table plus hand sequences,
// with expectations queued at drive time and compared one edge later.
module tb_ib_counter_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned PRE_W = 8;

  logic             i_clk = 1'b0;
  logic             i_nrst = 1'b0;
  logic             i_start = 1'b0;
  logic             i_stop = 1'b0;
  logic             i_mode = 1'b0;
  logic [WIDTH-1:0] i_limit = '0;
  logic [PRE_W-1:0] i_prescale = '0;
  logic             o_busy;
  logic [WIDTH-1:0] o_c;
  logic             o_done;
  logic [7:0]       o_periods;

  ib_counter_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_mode     (i_mode),
    .i_limit    (i_limit),
    .i_prescale (i_prescale),
    .o_busy     (o_busy),
    .o_c        (o_c),
    .o_done     (o_done),
    .o_periods  (o_periods)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic             busy;
    logic [WIDTH-1:0] c;
    logic             done;
    logic [7:0]       per;
  } exp_t;

  typedef struct packed {
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] lim;
    logic [PRE_W-1:0] psc;
    exp_t             e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t vec[20];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, ".busy"}, int'(o_busy), int'(e.busy));
    check({tag, ".c"}, int'(o_c), int'(e.c));
    check({tag, ".done"}, int'(o_done), int'(e.done));
    check({tag, ".periods"}, int'(o_periods), int'(e.per));
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input string tag, input logic st, input logic sp, input logic md,
                      input int lim, input int psc, input exp_t e);
    exp_t got;
    i_start    = st;
    i_stop     = sp;
    i_mode     = md;
    i_limit    = WIDTH'(lim);
    i_prescale = PRE_W'(psc);
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".queue"}, 0, 1);
    end else begin
      got = sb_q.pop_front();
      check_outs(tag, got);
    end
  endtask

  function automatic exp_t mk(input logic b, input int c, input logic d, input int p);
    mk.busy = b;
    mk.c    = WIDTH'(c);
    mk.done = d;
    mk.per  = 8'(p);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // Periodic lim=2 psc=1 with junk inputs mid-run, stop, then start+stop
    // in IDLE launching a one-shot lim=3 psc=0 run.
    vec[0]  = '{1'b1, 1'b0, 1'b1, 16'd2, 8'd1, mk(1, 0, 0, 0)};
    vec[1]  = '{1'b0, 1'b0, 1'b1, 16'd2, 8'd1, mk(1, 0, 0, 0)};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 16'd2, 8'd1, mk(1, 1, 0, 0)};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 16'd7, 8'd0, mk(1, 1, 0, 0)};
    vec[4]  = '{1'b0, 1'b0, 1'b0, 16'd5, 8'd3, mk(1, 2, 0, 0)};
    vec[5]  = '{1'b1, 1'b0, 1'b0, 16'd0, 8'd9, mk(1, 2, 0, 0)};
    vec[6]  = '{1'b0, 1'b0, 1'b1, 16'd2, 8'd1, mk(1, 0, 1, 1)};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 16'd2, 8'd1, mk(1, 0, 0, 1)};
    vec[8]  = '{1'b0, 1'b0, 1'b1, 16'd2, 8'd1, mk(1, 1, 0, 1)};
    vec[9]  = '{1'b0, 1'b0, 1'b1, 16'd2, 8'd1, mk(1, 1, 0, 1)};
    vec[10] = '{1'b0, 1'b0, 1'b1, 16'd2, 8'd1, mk(1, 2, 0, 1)};
    vec[11] = '{1'b0, 1'b0, 1'b1, 16'd2, 8'd1, mk(1, 2, 0, 1)};
    vec[12] = '{1'b0, 1'b0, 1'b1, 16'd2, 8'd1, mk(1, 0, 1, 2)};
    vec[13] = '{1'b0, 1'b1, 1'b1, 16'd2, 8'd1, mk(0, 0, 0, 2)};
    vec[14] = '{1'b1, 1'b1, 1'b0, 16'd3, 8'd0, mk(1, 0, 0, 0)};
    vec[15] = '{1'b0, 1'b0, 1'b0, 16'd3, 8'd0, mk(1, 1, 0, 0)};
    vec[16] = '{1'b0, 1'b0, 1'b0, 16'd3, 8'd0, mk(1, 2, 0, 0)};
    vec[17] = '{1'b0, 1'b0, 1'b0, 16'd3, 8'd0, mk(1, 3, 0, 0)};
    vec[18] = '{1'b0, 1'b0, 1'b0, 16'd3, 8'd0, mk(0, 3, 1, 0)};
    vec[19] = '{1'b0, 1'b1, 1'b1, 16'd3, 8'd0, mk(0, 3, 0, 0)};

    // Reset state
    #3;
    check_outs("reset", mk(0, 0, 0, 0));
    #4;
    i_nrst = 1'b1;
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 2; i++) step("idle_after_reset", 0, 0, 1, 5, 0, mk(0, 0, 0, 0));

    for (int i = 0; i < 20; i++) begin
      step($sformatf("vec%0d", i), vec[i].start, vec[i].stop, vec[i].mode,
           int'(vec[i].lim), int'(vec[i].psc), vec[i].e);
    end

    // Stop coinciding with the terminal tick
    step("stopterm0", 1, 0, 1, 1, 0, mk(1, 0, 0, 0));
    step("stopterm1", 0, 0, 1, 1, 0, mk(1, 1, 0, 0));
    step("stopterm2", 0, 1, 1, 1, 0, mk(0, 1, 0, 0));
    step("stopterm3", 0, 0, 1, 1, 0, mk(0, 1, 0, 0));

    // limit=0 prescale=0 periodic: done every cycle, periods wraps
    step("wrap_start", 1, 0, 1, 0, 0, mk(1, 0, 0, 0));
    for (int k = 1; k <= 300; k++) begin
      step($sformatf("wrap%0d", k), 0, 0, 1, 0, 0, mk(1, 0, 1, k % 256));
    end
    check("wrap_final_periods", int'(o_periods), 44);
    step("wrap_stop", 0, 1, 1, 0, 0, mk(0, 0, 0, 44));

    // Async reset between edges at o_c=5
    step("ar_start", 1, 0, 0, 9, 0, mk(1, 0, 0, 0));
    for (int k = 1; k <= 5; k++) step($sformatf("ar_run%0d", k), 0, 0, 0, 9, 0, mk(1, k, 0, 0));
    i_nrst = 1'b0;
    #2;
    check_outs("async_reset", mk(0, 0, 0, 0));
    #1;
    i_nrst = 1'b1;
    for (int k = 0; k < 3; k++) step("ar_idle", 0, 0, 0, 9, 0, mk(0, 0, 0, 0));
    step("ar_restart", 1, 0, 0, 9, 0, mk(1, 0, 0, 0));
    step("ar_restart1", 0, 0, 0, 9, 0, mk(1, 1, 0, 0));

    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
